alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 32-bit ALU between two requesters: req 0 = main datapath, req 1 = auxiliary unit (e.g. address/branch calc).
//  Round-robin grant, valid/ready handshake on request and response, operands and result registered.
//  Sits between the requesters and the ALU; drives the ALU X/Y/CONTROL inputs, samples RESULTADO/ZERO.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  CTRL_W  4   ALU CONTROL code width
// PORTS
//  CLK             in   1       clock, all state on rising edge
//  RST_n           in   1       asynchronous reset, active low
//  REQ_VALID[1:0]  in   2       request i presents operands
//  REQ_READY[1:0]  out  2       request i accepted this cycle when VALID&READY
//  REQ_X0, REQ_X1  in   WIDTH   X operand, requester 0/1 (signed)
//  REQ_Y0, REQ_Y1  in   WIDTH   Y operand, requester 0/1 (signed)
//  REQ_CTRL0/1     in   CTRL_W  ALU CONTROL code, requester 0/1
//  ALU_X, ALU_Y    out  WIDTH   to ALU operand inputs
//  ALU_CONTROL     out  CTRL_W  to ALU CONTROL
//  ALU_RESULTADO   in   WIDTH   from ALU result
//  ALU_ZERO        in   1       from ALU ZERO flag
//  RSP_VALID[1:0]  out  2       result ready for requester i (one-hot or zero)
//  RSP_READY[1:0]  in   2       requester i consumes response
//  RSP_RESULT      out  WIDTH   registered ALU result
//  RSP_ZERO        out  1       registered ZERO flag
//  BUSY            out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (RST_n=0, async): state=IDLE; operand/ctrl regs=0; RSP_RESULT=0; RSP_ZERO=0; RSP_VALID=0; owner=0; last_grant=1.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: grant computed combinationally from REQ_VALID and last_grant:
//   - only one valid -> grant it; both valid -> grant the one != last_grant; none -> no grant.
//   - REQ_READY = one-hot grant vector in IDLE; REQ_READY=0 in EXEC/RESP.
//   - on handshake: latch X, Y, CTRL of winner; owner<=winner; last_grant<=winner; ->EXEC.
//  EXEC (1 cycle): ALU inputs driven from latched regs; at end of cycle capture ALU_RESULTADO/ALU_ZERO into RSP regs; ->RESP.
//  RESP: RSP_VALID[owner]=1, other bit 0; RSP_RESULT/RSP_ZERO stable.
//   - RSP_READY[owner]=1 -> ->IDLE next cycle; RSP_READY of non-owner ignored; hold indefinitely otherwise.
//  ALU_X/ALU_Y/ALU_CONTROL always = latched regs (combinational ALU path spans one full cycle in EXEC).
//  Latency: accept at edge N, RSP_VALID high from cycle N+2; with RSP_READY held 1, next accept at edge N+3.
//  Throughput: one operation per 3 cycles max; no request overlap.
//  Width: operands passed unmodified; no sign handling here (ALU interprets CONTROL).
//  CONTROL codes passed through, including unused codes (ALU returns 0).
//  Request fields of a non-granted requester may change freely; only values at handshake matter.
//  Reset mid-operation: in-flight op dropped, no response issued; after release first grant favours req 0.
//  REQ_VALID deasserted in IDLE without handshake: no effect, no state change.
// TESTING
//  1 Reset then req0 only: X=5,Y=3,CTRL=0000 -> READY0 same cycle; RSP_VALID0 2 cycles later, RESULT=8, ZERO=0.
//  2 Both valid from reset: req0 SUB 7-7, req1 OR 0xF0|0x0F -> req0 first (RESULT=0, ZERO=1), then req1 (RESULT=0xFF); alternation continues for 4 ops.
//  3 Response back-pressure: RSP_READY0=0 for 5 cycles -> RSP_VALID0 and RESULT held, REQ_READY=00, BUSY=1 throughout.
//  4 Non-owner RSP_READY1=1 while owner=0 with RSP_READY0=0 -> no state change; RSP_VALID1 stays 0.
//  5 RST_n pulsed low during EXEC -> all outputs 0 immediately; no RSP_VALID after release; next grant to req0.
//  6 Req0 SLT X=-1,Y=1 (0100) -> RESULT=1; req1 SLTU same operands (1100) -> RESULT=0; verify CONTROL passthrough.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters (0 = main datapath, 1 = auxiliary unit).
// Round-robin grant, valid/ready on both request and response sides.
// Operands, control code and result are all registered, so one operation
// takes three cycles: accept, execute, respond.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; grant offered combinationally
// EXEC  | ALU evaluates latched operands; result captured at cycle end
// RESP  | response held to the owner until it raises its rsp_ready
module alu_arbiter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  logic [WIDTH-1:0]  req_x0_i,
    input  logic [WIDTH-1:0]  req_x1_i,
    input  logic [WIDTH-1:0]  req_y0_i,
    input  logic [WIDTH-1:0]  req_y1_i,
    input  logic [CTRL_W-1:0] req_ctrl0_i,
    input  logic [CTRL_W-1:0] req_ctrl1_i,
    output logic [WIDTH-1:0]  alu_x_o,
    output logic [WIDTH-1:0]  alu_y_o,
    output logic [CTRL_W-1:0] alu_control_o,
    input  logic [WIDTH-1:0]  alu_resultado_i,
    input  logic              alu_zero_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [WIDTH-1:0]  rsp_result_o,
    output logic              rsp_zero_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic               owner_q;
    logic               last_grant_q;
    logic [WIDTH-1:0]   rsp_result_q;
    logic               rsp_zero_q;
    logic [1:0]         rsp_valid_q;

    logic [1:0]         grant_d;
    logic               handshake_d;
    logic               winner_d;

    // Round-robin grant: a lone requester wins outright; on contention the
    // requester that did not win last time is preferred.
    always_comb begin
        grant_d = 2'b00;
        case (req_valid_i)
            2'b01:   grant_d = 2'b01;
            2'b10:   grant_d = 2'b10;
            2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
            default: grant_d = 2'b00;
        endcase
        req_ready_o = (state_q == S_IDLE) ? grant_d : 2'b00;
        handshake_d = |(req_valid_i & req_ready_o);
        winner_d    = grant_d[1];
    end

    // Sequencer: latch winner's operands, capture ALU result, hold response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            ctrl_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (handshake_d) begin
                        x_q          <= winner_d ? req_x1_i : req_x0_i;
                        y_q          <= winner_d ? req_y1_i : req_y0_i;
                        ctrl_q       <= winner_d ? req_ctrl1_i : req_ctrl0_i;
                        owner_q      <= winner_d;
                        last_grant_q <= winner_d;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_resultado_i;
                    rsp_zero_q   <= alu_zero_i;
                    rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    // Only the owner's ready matters; the other requester's is ignored.
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // ALU path is driven purely from the latched registers.
    always_comb begin
        alu_x_o       = x_q;
        alu_y_o       = y_q;
        alu_control_o = ctrl_q;
        rsp_valid_o   = rsp_valid_q;
        rsp_result_o  = rsp_result_q;
        rsp_zero_o    = rsp_zero_q;
        busy_o        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the ALU itself and as both requesters,
// predicting grants and results from a high-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [31:0] req_x0, req_x1, req_y0, req_y1;
    logic [3:0]  req_ctrl0, req_ctrl1;
    logic [31:0] alu_x, alu_y, alu_res;
    logic [3:0]  alu_control;
    logic        alu_zero;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, busy;

    int vectors = 0;
    int miscompares = 0;
    logic last_m;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_x0_i(req_x0), .req_x1_i(req_x1),
        .req_y0_i(req_y0), .req_y1_i(req_y1),
        .req_ctrl0_i(req_ctrl0), .req_ctrl1_i(req_ctrl1),
        .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_control_o(alu_control),
        .alu_resultado_i(alu_res), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
        .busy_o(busy)
    );

    // Behavioural ALU: ADD, SUB, AND, OR, SLT, XOR, SLTU; other codes give 0.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
        case (c)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd5:    return x ^ y;
            4'd12:   return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res  = alu_fn(alu_control, alu_x, alu_y);
    assign alu_zero = (alu_res == 32'd0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic r);
        return r ? 2'b10 : 2'b01;
    endfunction

    // One request/response transaction with `hold` cycles of owner back-pressure.
    task automatic do_txn(input logic [1:0] v, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [3:0] c0, input logic [31:0] x1, input logic [31:0] y1,
                          input logic [3:0] c1, input int hold);
        logic        g;
        logic [31:0] ex, ey, er;
        logic [3:0]  ec;
        req_valid = v;
        req_x0 = x0; req_y0 = y0; req_ctrl0 = c0;
        req_x1 = x1; req_y1 = y1; req_ctrl1 = c1;
        rsp_ready = 2'b00;
        #1;
        if (v == 2'b00) begin
            chk("idle_ready", {62'd0, req_ready}, 64'd0);
            @(posedge clk); #2;
            chk("idle_busy", {63'd0, busy}, 64'd0);
            return;
        end
        if (v == 2'b01)      g = 1'b0;
        else if (v == 2'b10) g = 1'b1;
        else                 g = ~last_m;
        ex = g ? x1 : x0;
        ey = g ? y1 : y0;
        ec = g ? c1 : c0;
        er = alu_fn(ec, ex, ey);
        chk("grant", {62'd0, req_ready}, {62'd0, onehot(g)});
        chk("busy_idle", {63'd0, busy}, 64'd0);

        @(posedge clk); #2;
        last_m = g;
        req_x0 = $urandom; req_y0 = $urandom; req_ctrl0 = 4'($urandom);
        req_x1 = $urandom; req_y1 = $urandom; req_ctrl1 = 4'($urandom);
        #1;
        chk("exec_x", {32'd0, alu_x}, {32'd0, ex});
        chk("exec_y", {32'd0, alu_y}, {32'd0, ey});
        chk("exec_ctrl", {60'd0, alu_control}, {60'd0, ec});
        chk("exec_busy", {63'd0, busy}, 64'd1);
        chk("exec_ready", {62'd0, req_ready}, 64'd0);
        chk("exec_rspv", {62'd0, rsp_valid}, 64'd0);

        @(posedge clk); #2;
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, onehot(g)});
        chk("rsp_result", {32'd0, rsp_result}, {32'd0, er});
        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, (er == 32'd0)});

        for (int i = 0; i < hold; i++) begin
            rsp_ready = (i % 2 == 1) ? onehot(~g) : 2'b00;
            @(posedge clk); #2;
            chk("hold_valid", {62'd0, rsp_valid}, {62'd0, onehot(g)});
            chk("hold_result", {32'd0, rsp_result}, {32'd0, er});
            chk("hold_busy", {63'd0, busy}, 64'd1);
            chk("hold_ready", {62'd0, req_ready}, 64'd0);
        end

        rsp_ready = onehot(g);
        @(posedge clk); #2;
        chk("done_valid", {62'd0, rsp_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        rsp_ready = 2'b00;
        req_valid = 2'b00;
    endtask

    initial begin
        logic [3:0] codes [8];
        logic [31:0] a, b;
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd9};
        rst_n = 1'b0;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
        req_ctrl0 = '0; req_ctrl1 = '0;
        last_m = 1'b1;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rspv", {62'd0, rsp_valid}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_alu_x", {32'd0, alu_x}, 64'd0);
        chk("rst_ctrl", {60'd0, alu_control}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Single requester ADD
        do_txn(2'b01, 32'd5, 32'd3, 4'd0, 32'd0, 32'd0, 4'd0, 0);

        // Contention: alternation, req0 first after reset
        rst_n = 1'b0; #1; rst_n = 1'b1; last_m = 1'b1;
        for (int k = 0; k < 4; k++)
            do_txn(2'b11, 32'd7, 32'd7, 4'd1, 32'hF0, 32'h0F, 4'd3, 0);

        // Owner back-pressure, non-owner ready toggling
        do_txn(2'b01, 32'd100, 32'd1, 4'd1, 32'd0, 32'd0, 4'd0, 5);
        do_txn(2'b10, 32'd0, 32'd0, 4'd0, 32'hAA, 32'h55, 4'd5, 4);

        // Signed vs unsigned compare
        do_txn(2'b01, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 32'd0, 4'd0, 0);
        do_txn(2'b10, 32'd0, 32'd0, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd12, 0);

        // Reset during EXEC drops the operation
        req_valid = 2'b10; req_x1 = 32'd9; req_y1 = 32'd4; req_ctrl1 = 4'd0;
        #1;
        chk("pre_rst_grant", {62'd0, req_ready}, 64'd2);
        @(posedge clk); #2;
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_rspv", {62'd0, rsp_valid}, 64'd0);
        chk("mid_rst_x", {32'd0, alu_x}, 64'd0);
        chk("mid_rst_y", {32'd0, alu_y}, 64'd0);
        chk("mid_rst_result", {32'd0, rsp_result}, 64'd0);
        #1;
        rst_n = 1'b1;
        last_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            chk("post_rst_rspv", {62'd0, rsp_valid}, 64'd0);
        end
        do_txn(2'b11, 32'd2, 32'd2, 4'd2, 32'd1, 32'd1, 4'd0, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_txn(2'($urandom), a, b, codes[$urandom_range(0, 7)],
                   $urandom, $urandom, codes[$urandom_range(0, 7)],
                   $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
